// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined floating-point adder/subtractor.
//   S1 unpacks/classifies both operands, orders them by magnitude and forms
//   the exponent difference; S2 aligns the smaller operand (guard/round/
//   sticky) and adds or subtracts; S3 normalises, rounds to nearest-even,
//   packs and raises flags. One operation per cycle, 2-cycle latency.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operand handshake (in_ready has no in_valid path)
//   in_a, in_b, in_sub       operands, 0: A+B, 1: A-B
//   out_valid/out_ready      result handshake
//   out_result               packed result
//   out_invalid/overflow/inexact  exception flags travelling with the result
module fp_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] in_a,
  input  logic [EXP_W+FRAC_W:0] in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] out_result,
  output logic                  out_invalid,
  output logic                  out_overflow,
  output logic                  out_inexact
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int XW = FRAC_W + 3;  // implicit + fraction + guard + round
  localparam int MW = FRAC_W + 4;  // ... + sticky
  localparam int SW = FRAC_W + 5;  // ... + carry-out
  localparam int EW = EXP_W + 2;   // headroom for carry and round increments
  localparam logic [EXP_W-1:0] E_ONES = {EXP_W{1'b1}};
  localparam logic [EW-1:0]    E_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  // ---------------- handshake / stall chain ----------------
  logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic s1_adv, s2_adv, s3_adv;

  always_comb begin
    s3_adv = !v3_q || out_ready;
    s2_adv = !v2_q || s3_adv;
    s1_adv = !v1_q || s2_adv;
    v1_d   = s1_adv ? in_valid : v1_q;
    v2_d   = s2_adv ? v1_q : v2_q;
    v3_d   = s3_adv ? v2_q : v3_q;
  end

  assign in_ready = s1_adv;

  // ---------------- S1: unpack, classify, order ----------------
  logic             s1_sign_q, s1_sign_d, s1_effsub_q, s1_effsub_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d, s1_diff_q, s1_diff_d;
  logic [FRAC_W:0]  s1_man1_q, s1_man1_d, s1_man2_q, s1_man2_d;
  logic             s1_spec_q, s1_spec_d, s1_inv_q, s1_inv_d, s1_negz_q, s1_negz_d;
  logic [W-1:0]     s1_sres_q, s1_sres_d;

  always_comb begin : stage1
    logic              a_sign, b_sign, x_sign, swap;
    logic              a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_clash;
    logic [EXP_W-1:0]  a_exp, b_exp, x_exp, y_exp, x_eff, y_eff;
    logic [FRAC_W-1:0] a_frac, b_frac, x_frac, y_frac;
    a_sign = in_a[W-1];
    a_exp  = in_a[W-2:FRAC_W];
    a_frac = in_a[FRAC_W-1:0];
    b_sign = in_b[W-1] ^ in_sub;  // subtraction = addition of negated B
    b_exp  = in_b[W-2:FRAC_W];
    b_frac = in_b[FRAC_W-1:0];
    a_inf  = (a_exp == E_ONES) && (a_frac == '0);
    b_inf  = (b_exp == E_ONES) && (b_frac == '0);
    a_nan  = (a_exp == E_ONES) && (a_frac != '0);
    b_nan  = (b_exp == E_ONES) && (b_frac != '0);
    a_snan = a_nan && !a_frac[FRAC_W-1];
    b_snan = b_nan && !b_frac[FRAC_W-1];
    inf_clash = a_inf && b_inf && (a_sign != b_sign);
    // op1 must have the larger magnitude so the subtraction never goes negative
    swap   = {b_exp, b_frac} > {a_exp, a_frac};
    x_sign = swap ? b_sign : a_sign;
    x_exp  = swap ? b_exp  : a_exp;
    y_exp  = swap ? a_exp  : b_exp;
    x_frac = swap ? b_frac : a_frac;
    y_frac = swap ? a_frac : b_frac;
    // subnormals use effective exponent 1 with implicit bit 0
    x_eff  = (x_exp == '0) ? EXP_W'(1) : x_exp;
    y_eff  = (y_exp == '0) ? EXP_W'(1) : y_exp;

    s1_sign_d   = s1_sign_q;
    s1_effsub_d = s1_effsub_q;
    s1_exp_d    = s1_exp_q;
    s1_diff_d   = s1_diff_q;
    s1_man1_d   = s1_man1_q;
    s1_man2_d   = s1_man2_q;
    s1_spec_d   = s1_spec_q;
    s1_inv_d    = s1_inv_q;
    s1_negz_d   = s1_negz_q;
    s1_sres_d   = s1_sres_q;
    if (s1_adv && in_valid) begin
      s1_sign_d   = x_sign;
      s1_effsub_d = a_sign ^ b_sign;
      s1_exp_d    = x_eff;
      s1_diff_d   = x_eff - y_eff;
      s1_man1_d   = {x_exp != '0, x_frac};
      s1_man2_d   = {y_exp != '0, y_frac};
      s1_negz_d   = a_sign && b_sign && ({a_exp, a_frac} == '0) && ({b_exp, b_frac} == '0);
      s1_spec_d   = a_nan || b_nan || a_inf || b_inf;
      s1_inv_d    = a_snan || b_snan || inf_clash;
      if (a_nan || b_nan || inf_clash) s1_sres_d = QNAN;
      else if (a_inf)                  s1_sres_d = {a_sign, E_ONES, {FRAC_W{1'b0}}};
      else                             s1_sres_d = {b_sign, E_ONES, {FRAC_W{1'b0}}};
    end
  end

  // ---------------- S2: align and add/subtract ----------------
  logic             s2_sign_q, s2_sign_d, s2_spec_q, s2_spec_d;
  logic             s2_inv_q, s2_inv_d, s2_negz_q, s2_negz_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [SW-1:0]    s2_sum_q, s2_sum_d;
  logic [W-1:0]     s2_sres_q, s2_sres_d;

  always_comb begin : stage2
    int              sh;
    logic [2*XW-1:0] wide;
    logic [MW-1:0]   op1, op2;
    // shifting by XW already pushes every bit into the sticky half
    sh   = (int'(s1_diff_q) > XW) ? XW : int'(s1_diff_q);
    wide = {s1_man2_q, 2'b00, {XW{1'b0}}} >> sh;
    op1  = {s1_man1_q, 3'b000};
    op2  = {wide[2*XW-1:XW], |wide[XW-1:0]};

    s2_sign_d = s2_sign_q;
    s2_exp_d  = s2_exp_q;
    s2_sum_d  = s2_sum_q;
    s2_spec_d = s2_spec_q;
    s2_inv_d  = s2_inv_q;
    s2_negz_d = s2_negz_q;
    s2_sres_d = s2_sres_q;
    if (s2_adv && v1_q) begin
      s2_sign_d = s1_sign_q;
      s2_exp_d  = s1_exp_q;
      s2_sum_d  = s1_effsub_q ? ({1'b0, op1} - {1'b0, op2}) : ({1'b0, op1} + {1'b0, op2});
      s2_spec_d = s1_spec_q;
      s2_inv_d  = s1_inv_q;
      s2_negz_d = s1_negz_q;
      s2_sres_d = s1_sres_q;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [W-1:0] res_q, res_d;
  logic         inv_q, inv_d, ovf_q, ovf_d, inx_q, inx_d;

  function automatic int lzc(input logic [MW-1:0] x);
    int n;
    n = MW;
    for (int i = 0; i < MW; i++) if (x[i]) n = MW - 1 - i;
    return n;
  endfunction

  always_comb begin : stage3
    logic [EW-1:0]     e;
    logic [MW-1:0]     m;
    logic [FRAC_W+1:0] rnd;
    logic              inexact;
    int                sh, cap;
    e   = EW'(s2_exp_q);
    m   = s2_sum_q[MW-1:0];
    sh  = 0;
    cap = 0;
    if (s2_sum_q[SW-1]) begin
      m = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      e = e + EW'(1);
    end else begin
      // left shift capped so the exponent stops at 1 (subnormal range)
      cap = int'(e) - 1;
      sh  = lzc(m);
      if (sh > cap) sh = cap;
      m = m << sh;
      e = e - EW'(sh);
    end
    inexact = m[2] | m[1] | m[0];
    rnd = {1'b0, m[MW-1:3]} + (FRAC_W+2)'(m[2] & (m[1] | m[0] | m[3]));
    if (rnd[FRAC_W+1]) begin
      rnd = rnd >> 1;
      e   = e + EW'(1);
    end

    res_d = res_q;
    inv_d = inv_q;
    ovf_d = ovf_q;
    inx_d = inx_q;
    if (s3_adv && v2_q) begin
      inv_d = 1'b0;
      ovf_d = 1'b0;
      inx_d = inexact;
      if (s2_spec_q) begin
        res_d = s2_sres_q;
        inv_d = s2_inv_q;
        inx_d = 1'b0;
      end else if (e >= E_MAX) begin
        res_d = {s2_sign_q, E_ONES, {FRAC_W{1'b0}}};
        ovf_d = 1'b1;
        inx_d = 1'b1;
      end else if (rnd[FRAC_W:0] == '0) begin
        res_d = {s2_negz_q, {(W-1){1'b0}}};
      end else begin
        // implicit bit 0 after normalising means subnormal: exponent field 0
        res_d = {s2_sign_q, (rnd[FRAC_W] ? e[EXP_W-1:0] : {EXP_W{1'b0}}), rnd[FRAC_W-1:0]};
      end
    end
  end

  assign out_valid    = v3_q;
  assign out_result   = res_q;
  assign out_invalid  = inv_q;
  assign out_overflow = ovf_q;
  assign out_inexact  = inx_q;

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      s1_sign_q <= 1'b0; s1_effsub_q <= 1'b0; s1_exp_q <= '0; s1_diff_q <= '0;
      s1_man1_q <= '0; s1_man2_q <= '0; s1_spec_q <= 1'b0; s1_inv_q <= 1'b0;
      s1_negz_q <= 1'b0; s1_sres_q <= '0;
      s2_sign_q <= 1'b0; s2_exp_q <= '0; s2_sum_q <= '0; s2_spec_q <= 1'b0;
      s2_inv_q <= 1'b0; s2_negz_q <= 1'b0; s2_sres_q <= '0;
      res_q <= '0; inv_q <= 1'b0; ovf_q <= 1'b0; inx_q <= 1'b0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      s1_sign_q <= s1_sign_d; s1_effsub_q <= s1_effsub_d; s1_exp_q <= s1_exp_d;
      s1_diff_q <= s1_diff_d; s1_man1_q <= s1_man1_d; s1_man2_q <= s1_man2_d;
      s1_spec_q <= s1_spec_d; s1_inv_q <= s1_inv_d; s1_negz_q <= s1_negz_d;
      s1_sres_q <= s1_sres_d;
      s2_sign_q <= s2_sign_d; s2_exp_q <= s2_exp_d; s2_sum_q <= s2_sum_d;
      s2_spec_q <= s2_spec_d; s2_inv_q <= s2_inv_d; s2_negz_q <= s2_negz_d;
      s2_sres_q <= s2_sres_d;
      res_q <= res_d; inv_q <= inv_d; ovf_q <= ovf_d; inx_q <= inx_d;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Testbench for fp_addsub_pipe: directed vector table, latency and stall
// sequences, random stream under pseudo-random backpressure checked against
// an exact real-arithmetic model, reset flush, and a half-precision build.
module tb_fp_addsub_pipe;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        inv;
    logic        ovf;
    logic        inx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic        out_invalid, out_overflow, out_inexact;

  logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_result;
  logic        h_out_invalid, h_out_overflow, h_out_inexact;

  logic        rand_rdy;
  logic [34:0] cur_exp;
  logic [34:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_invalid(out_invalid),
    .out_overflow(out_overflow), .out_inexact(out_inexact)
  );

  fp_addsub_pipe #(.EXP_W(5), .FRAC_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_result(h_out_result), .out_invalid(h_out_invalid),
    .out_overflow(h_out_overflow), .out_inexact(h_out_inexact)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic real fp_to_real(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0000_0000;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // operands with 9 significant bits and close exponents: the sum is exact
  function automatic vec_t rand_vec();
    vec_t v;
    real  r;
    v.a   = {1'($urandom_range(0, 1)), 8'($urandom_range(125, 130)), 8'($urandom_range(0, 255)), 15'd0};
    v.b   = {1'($urandom_range(0, 1)), 8'($urandom_range(125, 130)), 8'($urandom_range(0, 255)), 15'd0};
    v.sub = 1'($urandom_range(0, 1));
    r     = v.sub ? fp_to_real(v.a) - fp_to_real(v.b) : fp_to_real(v.a) + fp_to_real(v.b);
    v.res = real_to_fp(r);
    v.inv = 1'b0;
    v.ovf = 1'b0;
    v.inx = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_sub   = v.sub;
    cur_exp  = {v.inv, v.ovf, v.inx, v.res};
  endtask

  task automatic send_op(input vec_t v);
    logic acc;
    int   budget;
    acc    = 1'b0;
    budget = 100;
    drive(v);
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      budget--;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 for 100 cycles, want 1");
    end
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vec_t vecs[18];
    vec_t v4;
    int   hb;
    logic hacc;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{32'h3F800000, 32'h2F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    out_ready = 1'b1; rand_rdy = 1'b0; cur_exp = '0;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_sub = 1'b0; h_out_ready = 1'b1;

    fork
      // scoreboard: every cycle a result is presented it must equal the head
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (out_valid) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL spurious_output: got %h, want no result", out_result);
            end else begin
              check("result", 64'({out_invalid, out_overflow, out_inexact, out_result}), 64'(exp_q[0]));
              if (out_ready) void'(exp_q.pop_front());
            end
          end
          if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
      end
      forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
    join_none

    // reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_flags", 64'({out_invalid, out_overflow, out_inexact}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // latency: accept at edge N, out_valid after edge N+2
    drive(vecs[0]);
    @(negedge clk);
    check("lat_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("lat_edge_n", 64'(out_valid), 64'd0);
    tick();
    check("lat_edge_n1", 64'(out_valid), 64'd0);
    tick();
    check("lat_edge_n2", 64'(out_valid), 64'd1);
    tick();
    tick();

    // directed table, back to back
    for (int i = 1; i < 18; i++) send_op(vecs[i]);
    drain();

    // fill the pipe with no consumer, then pass-through on a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_op(rand_vec());
    v4 = rand_vec();
    drive(v4);
    repeat (2) begin
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("pass_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    drain();

    // random stream under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) send_op(rand_vec());
    drain();
    rand_rdy = 1'b0;
    tick();
    out_ready = 1'b1;

    // reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_op(rand_vec());
    #3;
    rst_n = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    check("flush_idle", 64'(out_valid), 64'd0);
    send_op(vecs[0]);
    drain();

    // half-precision build
    h_in_valid = 1'b1; h_in_a = 16'h3C00; h_in_b = 16'h3C00; h_in_sub = 1'b0;
    hacc = 1'b0;
    hb   = 0;
    while (!hacc && hb < 10) begin
      @(negedge clk);
      hacc = h_in_ready;
      tick();
      hb++;
    end
    h_in_valid = 1'b0;
    hb = 0;
    while (!h_out_valid && hb < 10) begin
      tick();
      hb++;
    end
    check("half_valid", 64'(h_out_valid), 64'd1);
    check("half_result", 64'({h_out_invalid, h_out_overflow, h_out_inexact, h_out_result}), 64'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
